fwd_hazard_unit: RTL and testbench

//  Tracks destination registers of the instructions in EX, MEM and WB, and drives the
//  2-bit operand selects of the two EX-stage forwarding muxes.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/fwd_hazard_unit_if.sv | 30 +++
 rtl/fwd_select.sv | 26 ++
 rtl/fwd_hazard_unit.sv | 92 +++++++++
 tb/tb_fwd_hazard_unit.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the forwarding / hazard logic: select encodings,
// register address width and the pipeline-slot records.
package cpu_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              uses_rt;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
        logic              valid;
    } ex_slot_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
        logic              valid;
    } mem_slot_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              valid;
    } wb_slot_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Decode-side bundle into the hazard unit and the select/stall results back out.
interface fwd_hazard_unit_if
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rt;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              flush;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              stall;
    logic              ex_valid;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_regwrite, id_memread, flush,
        input  fwd_a_sel, fwd_b_sel, stall, ex_valid, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_regwrite, id_memread, flush,
        output fwd_a_sel, fwd_b_sel, stall, ex_valid, stall_count
    );
endinterface

// File: rtl/fwd_select.sv
// Per-operand forwarding priority: youngest non-load producer in MEM wins,
// then WB; register 0 is never forwarded.
module fwd_select
    import cpu_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  logic              use_src,
    input  mem_slot_t         mem_slot,
    input  wb_slot_t          wb_slot,
    output logic [1:0]        sel
);

    // Priority compare of the source register against the MEM and WB producers
    always_comb begin
        sel = FWD_RF;
        if (use_src && (src != '0)) begin
            if (mem_slot.valid && mem_slot.regwrite && !mem_slot.memread
                && (mem_slot.rd == src)) begin
                sel = FWD_EXMEM;
            end else if (wb_slot.valid && wb_slot.regwrite && (wb_slot.rd == src)) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Tracks the EX/MEM/WB destination registers, drives the EX operand-mux
// selects and requests a one-cycle stall on a load-use dependency.
module fwd_hazard_unit
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    fwd_hazard_unit_if.slave  bus
);

    ex_slot_t         ex_q,  ex_d;
    mem_slot_t        mem_q, mem_d;
    wb_slot_t         wb_q,  wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hz;
    logic             stall;
    logic [1:0]       sel_a;
    logic [1:0]       sel_b;

    // Load in EX whose destination is read by the instruction in ID
    always_comb begin
        hz = ex_q.valid && ex_q.memread && ex_q.regwrite && (ex_q.rd != '0)
             && bus.id_valid
             && ((bus.id_rs == ex_q.rd) || (bus.id_uses_rt && (bus.id_rt == ex_q.rd)));
        stall = hz && !bus.flush;
    end

    // Slot advance; a stall or flush turns the incoming EX entry into a bubble
    always_comb begin
        ex_d = '0;
        if (!(stall || bus.flush)) begin
            ex_d.rs       = bus.id_rs;
            ex_d.rt       = bus.id_rt;
            ex_d.uses_rt  = bus.id_uses_rt;
            ex_d.rd       = bus.id_rd;
            ex_d.regwrite = bus.id_regwrite;
            ex_d.memread  = bus.id_memread;
            ex_d.valid    = bus.id_valid;
        end
        mem_d.rd       = ex_q.rd;
        mem_d.regwrite = ex_q.regwrite;
        mem_d.memread  = ex_q.memread;
        mem_d.valid    = ex_q.valid;
        wb_d.rd        = mem_q.rd;
        wb_d.regwrite  = mem_q.regwrite;
        wb_d.valid     = mem_q.valid;
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Slot and statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    fwd_select u_sel_a (
        .src      (ex_q.rs),
        .use_src  (ex_q.valid),
        .mem_slot (mem_q),
        .wb_slot  (wb_q),
        .sel      (sel_a)
    );

    fwd_select u_sel_b (
        .src      (ex_q.rt),
        .use_src  (ex_q.valid && ex_q.uses_rt),
        .mem_slot (mem_q),
        .wb_slot  (wb_q),
        .sel      (sel_b)
    );

    assign bus.fwd_a_sel   = sel_a;
    assign bus.fwd_b_sel   = sel_b;
    assign bus.stall       = stall;
    assign bus.ex_valid    = ex_q.valid;
    assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed pipeline scenarios plus random traffic,
// all checked against an instruction-level pipeline model.
module tb_fwd_hazard_unit;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.CNT_W(32)) bus ();
    fwd_hazard_unit_if #(.CNT_W(2))  bus2 ();

    fwd_hazard_unit #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    fwd_hazard_unit #(.CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .bus(bus2.slave));

    assign bus2.id_valid    = bus.id_valid;
    assign bus2.id_rs       = bus.id_rs;
    assign bus2.id_rt       = bus.id_rt;
    assign bus2.id_uses_rt  = bus.id_uses_rt;
    assign bus2.id_rd       = bus.id_rd;
    assign bus2.id_regwrite = bus.id_regwrite;
    assign bus2.id_memread  = bus.id_memread;
    assign bus2.flush       = bus.flush;

    typedef struct {
        bit valid;
        int rs;
        int rt;
        bit ut;
        int rd;
        bit rw;
        bit mr;
    } ins_t;

    ins_t    pipe[3];          // 0 = EX, 1 = MEM, 2 = WB
    longint  m_cnt;
    bit      model_known = 0;
    int      errors = 0;
    int      checks = 0;

    logic [1:0]  obs_a, obs_b;
    logic        obs_stall, obs_exv;
    logic [31:0] obs_cnt;
    logic [1:0]  obs_cnt2;

    // Youngest older instruction that writes src and whose result exists yet
    function automatic int exp_sel(int src, bit en);
        if (!en || src == 0) return 0;
        for (int i = 1; i <= 2; i++) begin
            if (pipe[i].valid && pipe[i].rw && pipe[i].rd == src && !(i == 1 && pipe[i].mr))
                return i;
        end
        return 0;
    endfunction

    task automatic issue(bit v, int rs, int rt, bit ut, int rd, bit rw, bit mr, bit fl, bit r);
        ins_t id;
        bit   e_stall;
        int   e_a, e_b;
        longint e_sat;
        @(negedge clk);
        bus.id_valid    = v;
        bus.id_rs       = REG_AW'(rs);
        bus.id_rt       = REG_AW'(rt);
        bus.id_uses_rt  = ut;
        bus.id_rd       = REG_AW'(rd);
        bus.id_regwrite = rw;
        bus.id_memread  = mr;
        bus.flush       = fl;
        rst             = r;
        #1;
        obs_a     = bus.fwd_a_sel;
        obs_b     = bus.fwd_b_sel;
        obs_stall = bus.stall;
        obs_exv   = bus.ex_valid;
        obs_cnt   = bus.stall_count;
        obs_cnt2  = bus2.stall_count;
        id = '{v, rs, rt, ut, rd, rw, mr};
        e_stall = pipe[0].valid && pipe[0].mr && pipe[0].rw && pipe[0].rd != 0 && v
                  && (rs == pipe[0].rd || (ut && rt == pipe[0].rd)) && !fl;
        if (model_known) begin
            e_a   = exp_sel(pipe[0].rs, pipe[0].valid);
            e_b   = exp_sel(pipe[0].rt, pipe[0].valid && pipe[0].ut);
            e_sat = (m_cnt > 3) ? 3 : m_cnt;
            checks += 6;
            if (obs_a !== 2'(e_a)) begin
                errors++; $display("FAIL model_fwd_a t=%0t got %b want %0d", $time, obs_a, e_a);
            end
            if (obs_b !== 2'(e_b)) begin
                errors++; $display("FAIL model_fwd_b t=%0t got %b want %0d", $time, obs_b, e_b);
            end
            if (obs_stall !== e_stall) begin
                errors++; $display("FAIL model_stall t=%0t got %b want %b", $time, obs_stall, e_stall);
            end
            if (obs_exv !== pipe[0].valid) begin
                errors++; $display("FAIL model_ex_valid t=%0t got %b want %b", $time, obs_exv, pipe[0].valid);
            end
            if (obs_cnt !== 32'(m_cnt)) begin
                errors++; $display("FAIL model_stall_count t=%0t got %0d want %0d", $time, obs_cnt, m_cnt);
            end
            if (obs_cnt2 !== 2'(e_sat)) begin
                errors++; $display("FAIL sat_stall_count t=%0t got %0d want %0d", $time, obs_cnt2, e_sat);
            end
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0, 0, 0, 0};
            m_cnt = 0;
            model_known = 1;
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (e_stall || fl) pipe[0] = '{0, 0, 0, 0, 0, 0, 0};
            else               pipe[0] = id;
            if (e_stall) m_cnt++;
        end
    endtask

    task automatic nop();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) nop();
    endtask

    task automatic test_reset();
        issue(1, 1, 2, 1, 3, 1, 0, 0, 1);
        issue(1, 3, 3, 1, 4, 1, 1, 0, 1);
        issue(1, 4, 4, 1, 5, 1, 0, 0, 0);
        checks++;
        if (obs_a !== 2'b00 || obs_b !== 2'b00 || obs_stall !== 1'b0 || obs_exv !== 1'b0 || obs_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_state got a=%b b=%b stall=%b exv=%b cnt=%0d want 00 00 0 0 0",
                     obs_a, obs_b, obs_stall, obs_exv, obs_cnt);
        end
    endtask

    task automatic test_exmem_fwd();
        drain();
        issue(1, 1, 2, 1, 3, 1, 0, 0, 0);   // add r3,r1,r2
        issue(1, 3, 5, 1, 4, 1, 0, 0, 0);   // sub r4,r3,r5
        nop();
        checks++;
        if (obs_a !== 2'b01 || obs_b !== 2'b00) begin
            errors++; $display("FAIL exmem_fwd got a=%b b=%b want 01 00", obs_a, obs_b);
        end
    endtask

    task automatic test_priority();
        drain();
        issue(1, 1, 2, 1, 3, 1, 0, 0, 0);
        issue(1, 4, 5, 1, 3, 1, 0, 0, 0);
        issue(1, 3, 3, 1, 6, 1, 0, 0, 0);   // or r6,r3,r3
        nop();
        checks++;
        if (obs_a !== 2'b01 || obs_b !== 2'b01) begin
            errors++; $display("FAIL priority_mem got a=%b b=%b want 01 01", obs_a, obs_b);
        end
        drain();
        issue(1, 1, 2, 1, 3, 1, 0, 0, 0);
        issue(1, 4, 5, 1, 3, 1, 0, 0, 0);
        nop();
        issue(1, 3, 3, 1, 6, 1, 0, 0, 0);
        nop();
        checks++;
        if (obs_a !== 2'b10 || obs_b !== 2'b10) begin
            errors++; $display("FAIL priority_wb got a=%b b=%b want 10 10", obs_a, obs_b);
        end
    endtask

    task automatic test_load_use();
        drain();
        issue(1, 1, 0, 0, 2, 1, 1, 0, 0);   // lw r2
        issue(1, 2, 1, 1, 7, 1, 0, 0, 0);   // add r7,r2,r1 -> stall
        checks++;
        if (obs_stall !== 1'b1 || obs_cnt !== 32'd0) begin
            errors++; $display("FAIL load_use_stall got stall=%b cnt=%0d want 1 0", obs_stall, obs_cnt);
        end
        issue(1, 2, 1, 1, 7, 1, 0, 0, 0);   // add held in ID
        checks++;
        if (obs_stall !== 1'b0 || obs_exv !== 1'b0 || obs_cnt !== 32'd1) begin
            errors++; $display("FAIL load_use_bubble got stall=%b exv=%b cnt=%0d want 0 0 1",
                               obs_stall, obs_exv, obs_cnt);
        end
        nop();
        checks++;
        if (obs_exv !== 1'b1 || obs_a !== 2'b10 || obs_b !== 2'b00) begin
            errors++; $display("FAIL load_use_fwd got exv=%b a=%b b=%b want 1 10 00", obs_exv, obs_a, obs_b);
        end
    endtask

    task automatic test_r0_unused_rt();
        drain();
        issue(1, 1, 1, 1, 0, 1, 1, 0, 0);   // lw r0
        issue(1, 0, 0, 1, 1, 1, 0, 0, 0);   // add r1,r0,r0
        checks++;
        if (obs_stall !== 1'b0) begin
            errors++; $display("FAIL r0_stall got %b want 0", obs_stall);
        end
        nop();
        checks++;
        if (obs_exv !== 1'b1 || obs_a !== 2'b00 || obs_b !== 2'b00) begin
            errors++; $display("FAIL r0_sel got exv=%b a=%b b=%b want 1 00 00", obs_exv, obs_a, obs_b);
        end
        drain();
        issue(1, 1, 1, 1, 2, 1, 1, 0, 0);   // lw r2
        issue(1, 4, 2, 0, 5, 1, 0, 0, 0);   // addi with rt = r2 unused
        checks++;
        if (obs_stall !== 1'b0) begin
            errors++; $display("FAIL unused_rt_stall got %b want 0", obs_stall);
        end
        nop();
        checks++;
        if (obs_exv !== 1'b1 || obs_a !== 2'b00 || obs_b !== 2'b00) begin
            errors++; $display("FAIL unused_rt_sel got exv=%b a=%b b=%b want 1 00 00", obs_exv, obs_a, obs_b);
        end
    endtask

    task automatic test_flush_vs_stall();
        drain();
        issue(1, 1, 1, 1, 2, 1, 1, 0, 0);   // lw r2
        issue(1, 2, 0, 0, 4, 1, 0, 1, 0);   // reads r2, flush
        checks++;
        if (obs_stall !== 1'b0 || obs_cnt !== 32'd1) begin
            errors++; $display("FAIL flush_stall got stall=%b cnt=%0d want 0 1", obs_stall, obs_cnt);
        end
        nop();
        checks++;
        if (obs_exv !== 1'b0 || obs_cnt !== 32'd1) begin
            errors++; $display("FAIL flush_bubble got exv=%b cnt=%0d want 0 1", obs_exv, obs_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        drain();
        issue(1, 1, 1, 1, 3, 1, 0, 0, 0);   // add r3
        issue(1, 1, 1, 1, 5, 1, 0, 0, 0);   // add r5
        issue(1, 1, 1, 1, 2, 1, 1, 0, 0);   // lw r2
        issue(1, 3, 5, 1, 6, 1, 0, 0, 1);   // reset with all slots full
        issue(1, 5, 2, 1, 7, 1, 0, 0, 0);   // reads r5, r2
        checks++;
        if (obs_stall !== 1'b0 || obs_exv !== 1'b0 || obs_cnt !== 32'd0) begin
            errors++; $display("FAIL midreset_clear got stall=%b exv=%b cnt=%0d want 0 0 0",
                               obs_stall, obs_exv, obs_cnt);
        end
        nop();
        checks++;
        if (obs_exv !== 1'b1 || obs_a !== 2'b00 || obs_b !== 2'b00) begin
            errors++; $display("FAIL midreset_sel got exv=%b a=%b b=%b want 1 00 00", obs_exv, obs_a, obs_b);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            issue($urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 79) == 0);
        end
    endtask

    initial begin
        bus.id_valid = 0; bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 0;
        bus.id_rd = '0; bus.id_regwrite = 0; bus.id_memread = 0; bus.flush = 0;
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0, 0, 0, 0};
        m_cnt = 0;
        test_reset();
        test_exmem_fwd();
        test_priority();
        test_load_use();
        test_r0_unused_rt();
        test_flush_vs_stall();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
